instruction_fetch_queue: RTL and testbench

- Parametrised successor of the single-register IF stage.
- Drives a PC generator into the I-cache and buffers fetched instructions in a QDEPTH-entry FIFO.
- Decode consumes from the FIFO through a valid/ready handshake, so memory stalls and decode back-pressure are decoupled.
- Supports branch redirect with flush, a predicted-taken tag per entry, and optional byte-swap of memory data.

---
 rtl/instruction_fetch_queue_if.sv | 38 +++
 rtl/instruction_fetch_queue.sv | 115 +++++++++++
 tb/tb_instruction_fetch_queue.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_queue_if.sv
// rtl/instruction_fetch_queue_if.sv - fetch queue bus bundle (redirect, I-cache port, decode stream)
// Ports (signals):
//   redirect, redirect_pc, redirect_taken : branch redirect request
//   I_addr, I_ren, I_rdata, I_stall       : I-cache word port
//   out_valid, out_ready, out_inst,
//   out_pc, out_taken                     : decode stream (valid/ready)
//   q_count                               : queue occupancy
// Modports: master = fetch queue side, slave = environment (core / cache) side.
interface instruction_fetch_queue_if #(
  parameter int XLEN   = 32,
  parameter int QDEPTH = 4
);
  localparam int CW = $clog2(QDEPTH + 1);

  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_taken;
  logic [XLEN-3:0] I_addr;
  logic            I_ren;
  logic [31:0]     I_rdata;
  logic            I_stall;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_inst;
  logic [XLEN-1:0] out_pc;
  logic            out_taken;
  logic [CW-1:0]   q_count;

  modport master (
    input  redirect, redirect_pc, redirect_taken, I_rdata, I_stall, out_ready,
    output I_addr, I_ren, out_valid, out_inst, out_pc, out_taken, q_count
  );

  modport slave (
    output redirect, redirect_pc, redirect_taken, I_rdata, I_stall, out_ready,
    input  I_addr, I_ren, out_valid, out_inst, out_pc, out_taken, q_count
  );
endinterface

// File: rtl/instruction_fetch_queue.sv
// rtl/instruction_fetch_queue.sv - PC generator plus QDEPTH-entry instruction FIFO toward decode
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : instruction_fetch_queue_if.master (redirect, I-cache port, decode stream, q_count)
module instruction_fetch_queue #(
  parameter int              XLEN       = 32,
  parameter int              QDEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter bit              SWAP_BYTES = 1'b1,
  parameter logic [31:0]     NOP_INST   = 32'h0000_0013
) (
  input  logic                              clk,
  input  logic                              rst_n,
  instruction_fetch_queue_if.master         bus
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            tag_pend_q, tag_pend_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;

  logic [31:0]     inst_mem_q  [QDEPTH];
  logic [31:0]     inst_mem_d  [QDEPTH];
  logic [XLEN-1:0] pc_mem_q    [QDEPTH];
  logic [XLEN-1:0] pc_mem_d    [QDEPTH];
  logic            taken_mem_q [QDEPTH];
  logic            taken_mem_d [QDEPTH];

  logic            not_full;
  logic            not_empty;
  logic            push;
  logic            pop;
  logic [31:0]     rdata_sw;

  assign not_full  = (count_q < DEPTH_C);
  assign not_empty = (count_q != '0);

  // Memory returns the big-endian word; flip byte order into instruction order.
  assign rdata_sw = SWAP_BYTES ? {bus.I_rdata[7:0], bus.I_rdata[15:8],
                                  bus.I_rdata[23:16], bus.I_rdata[31:24]}
                               : bus.I_rdata;

  // Redirect squashes both the incoming fetch and any head handshake.
  assign push = not_full & ~bus.I_stall & ~bus.redirect;
  assign pop  = not_empty & bus.out_ready & ~bus.redirect;

  // Outputs depend only on registered state.
  assign bus.I_ren     = not_full;
  assign bus.I_addr    = fetch_pc_q[XLEN-1:2];
  assign bus.out_valid = not_empty;
  assign bus.out_inst  = not_empty ? inst_mem_q[rd_ptr_q]  : NOP_INST;
  assign bus.out_pc    = not_empty ? pc_mem_q[rd_ptr_q]    : '0;
  assign bus.out_taken = not_empty ? taken_mem_q[rd_ptr_q] : 1'b0;
  assign bus.q_count   = count_q;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    tag_pend_d  = tag_pend_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    inst_mem_d  = inst_mem_q;
    pc_mem_d    = pc_mem_q;
    taken_mem_d = taken_mem_q;

    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_pc;
      tag_pend_d = bus.redirect_taken;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (push) begin
        inst_mem_d[wr_ptr_q]  = rdata_sw;
        pc_mem_d[wr_ptr_q]    = fetch_pc_q;
        taken_mem_d[wr_ptr_q] = tag_pend_q;
        wr_ptr_d              = wr_ptr_q + PW'(1);
        fetch_pc_d            = fetch_pc_q + XLEN'(4);
        tag_pend_d            = 1'b0;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      tag_pend_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      tag_pend_q <= tag_pend_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Entry storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    inst_mem_q  <= inst_mem_d;
    pc_mem_q    <= pc_mem_d;
    taken_mem_q <= taken_mem_d;
  end
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb/tb_instruction_fetch_queue.sv - randomized bench for instruction_fetch_queue against a queue model
module tb_instruction_fetch_queue;
  localparam int          XLEN     = 32;
  localparam int          QDEPTH   = 4;
  localparam logic [31:0] RESET_PC = 32'h100;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  instruction_fetch_queue_if #(.XLEN(XLEN), .QDEPTH(QDEPTH)) bus ();

  instruction_fetch_queue #(
    .XLEN(XLEN), .QDEPTH(QDEPTH), .RESET_PC(RESET_PC),
    .SWAP_BYTES(1'b1), .NOP_INST(NOP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        taken;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic        m_tag;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = w[8*(3-b) +: 8];
    return r;
  endfunction

  // Reference: a plain bounded queue; fetch and decode decisions use pre-edge occupancy.
  task automatic model_edge();
    bit   do_pop;
    bit   do_push;
    ent_t e;
    if (!rst_n) begin
      mq.delete();
      m_pc  = RESET_PC;
      m_tag = 1'b0;
    end else if (bus.redirect) begin
      mq.delete();
      m_pc  = bus.redirect_pc;
      m_tag = bus.redirect_taken;
    end else begin
      do_pop  = (mq.size() > 0) && bus.out_ready;
      do_push = (mq.size() < QDEPTH) && !bus.I_stall;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        e.inst  = bswap(bus.I_rdata);
        e.pc    = m_pc;
        e.taken = m_tag;
        mq.push_back(e);
        m_pc  = m_pc + 32'd4;
        m_tag = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    int n;
    n = mq.size();
    chk("q_count",   64'(bus.q_count),   64'(n));
    chk("out_valid", 64'(bus.out_valid), 64'(n != 0));
    chk("out_inst",  64'(bus.out_inst),  64'(n != 0 ? mq[0].inst : NOP));
    chk("out_pc",    64'(bus.out_pc),    64'(n != 0 ? mq[0].pc : 32'h0));
    chk("out_taken", 64'(bus.out_taken), 64'(n != 0 ? mq[0].taken : 1'b0));
    chk("I_ren",     64'(bus.I_ren),     64'(n < QDEPTH));
    chk("I_addr",    64'(bus.I_addr),    64'(m_pc[31:2]));
  endtask

  task automatic step(input logic rn, input logic rd, input logic [31:0] rpc,
                      input logic rt, input logic stall, input logic ready,
                      input logic [31:0] rdata);
    rst_n              = rn;
    bus.redirect       = rd;
    bus.redirect_pc    = rpc;
    bus.redirect_taken = rt;
    bus.I_stall        = stall;
    bus.out_ready      = ready;
    bus.I_rdata        = rdata;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic [31:0] rpc;
    mq.delete();
    m_pc  = RESET_PC;
    m_tag = 1'b0;

    // Reset, then streaming with the NOP-encoded big-endian word.
    step(0, 0, 0, 0, 0, 1, 32'h1300_0000);
    step(0, 0, 0, 0, 0, 1, 32'h1300_0000);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 1, 32'h1300_0000);

    // Back-pressure until full, single pop, refill.
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0, 0, $urandom);
    step(1, 0, 0, 0, 0, 1, $urandom);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, $urandom);

    // Stall while draining to empty.
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 1, 1, $urandom);

    // Build three entries then redirect with taken tag.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, $urandom);
    step(1, 1, 32'h2000, 1, 0, 0, $urandom);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, $urandom);

    // Full queue: redirect together with ready and stall.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, $urandom);
    step(1, 1, 32'h3002, 0, 1, 1, $urandom);
    step(1, 1, 32'h3010, 1, 0, 1, $urandom);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, $urandom);

    // Reset during stall with full queue.
    step(0, 0, 0, 0, 1, 0, $urandom);
    step(1, 0, 0, 0, 0, 1, $urandom);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rpc = $urandom;
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 19) == 0),
           rpc,
           1'($urandom),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) != 0),
           $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
